// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit big-endian blocks
// and appends 0x80, zero fill and the bit length. Optional macro: SHA256_PAD_OVF_EN (len_ovf port).
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         CLK,
  input  logic         nreset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
`ifdef SHA256_PAD_OVF_EN
  ,
  output logic         len_ovf
`endif
);

  typedef enum logic [1:0] {ACCEPT, PAD, EMIT, LEN} state_t;

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [511:0]       buf_q, buf_d;
  logic               first_q, first_d;
  logic               pad_pending_q, pad_pending_d;
  logic               need_len_q, need_len_d;
  logic               final_q, final_d;
  logic [63:0]        len64;
`ifdef SHA256_PAD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    first_d       = first_q;
    pad_pending_d = pad_pending_q;
    need_len_d    = need_len_q;
    final_d       = final_q;
`ifdef SHA256_PAD_OVF_EN
    ovf_d         = ovf_q;
`endif
    len64                = '0;
    len64[LEN_W-1:0]     = cnt_q;

    case (state_q)
      ACCEPT: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < 64; i++) begin
            if (6'(i) == idx_q) buf_d[511-8*i -: 8] = in_data;
          end
          idx_d = idx_q + 6'd1;
          cnt_d = cnt_q + LEN_W'(8);
`ifdef SHA256_PAD_OVF_EN
          // Counter only ever holds multiples of 8, so +8 carries out iff the upper bits are all ones.
          if (&cnt_q[LEN_W-1:3]) ovf_d = 1'b1;
`endif
          if (in_last) begin
            if (idx_q == 6'd63) begin
              state_d       = EMIT;
              pad_pending_d = 1'b1;
            end else begin
              state_d = PAD;
            end
          end else if (idx_q == 6'd63) begin
            state_d = EMIT;
          end
        end
      end

      PAD: begin
        for (int unsigned i = 0; i < 64; i++) begin
          if (6'(i) == idx_q)     buf_d[511-8*i -: 8] = 8'h80;
          else if (6'(i) > idx_q) buf_d[511-8*i -: 8] = 8'h00;
        end
        if (idx_q <= 6'd55) begin
          buf_d[63:0] = len64;
          final_d     = 1'b1;
        end else begin
          need_len_d = 1'b1;
          final_d    = 1'b0;
        end
        state_d = EMIT;
      end

      EMIT: begin
        if (blk_ready) begin
          first_d = 1'b0;
          final_d = 1'b0;
          if (pad_pending_q) begin
            idx_d         = '0;
            pad_pending_d = 1'b0;
            state_d       = PAD;
          end else if (need_len_q) begin
            need_len_d = 1'b0;
            state_d    = LEN;
          end else if (final_q) begin
            idx_d   = '0;
            cnt_d   = '0;
            first_d = 1'b1;
            buf_d   = '0;
            state_d = ACCEPT;
`ifdef SHA256_PAD_OVF_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            idx_d   = '0;
            state_d = ACCEPT;
          end
        end
      end

      LEN: begin
        buf_d       = '0;
        buf_d[63:0] = len64;
        final_d     = 1'b1;
        state_d     = EMIT;
      end

      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ACCEPT;
      idx_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      first_q       <= 1'b1;
      pad_pending_q <= 1'b0;
      need_len_q    <= 1'b0;
      final_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      first_q       <= first_d;
      pad_pending_q <= pad_pending_d;
      need_len_q    <= need_len_d;
      final_q       <= final_d;
    end
  end

`ifdef SHA256_PAD_OVF_EN
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end
  assign len_ovf = ovf_q;
`endif

  // in_ready is gated by nreset so it reads 0 while reset is held.
  assign in_ready  = nreset && (state_q == ACCEPT);
  assign blk_valid = (state_q == EMIT);
  assign blk_first = (state_q == EMIT) && first_q;
  assign blk_last  = (state_q == EMIT) && final_q;
  assign blk_data  = buf_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized self-checking bench for sha256_msg_padder against a byte-level padding model.
module tb_sha256_msg_padder;

`ifdef SHA256_PAD_OVF_EN
  localparam int unsigned LW = 8;
`else
  localparam int unsigned LW = 64;
`endif

  logic         CLK = 1'b0;
  logic         nreset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;
`ifdef SHA256_PAD_OVF_EN
  logic         len_ovf;
`endif

  sha256_msg_padder #(.LEN_W(LW)) dut (
    .CLK       (CLK),
    .nreset    (nreset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last)
`ifdef SHA256_PAD_OVF_EN
    ,
    .len_ovf   (len_ovf)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];
  logic [511:0] last_rx;
  int unsigned  last_xfer_cyc;
  bit           iv_rand;
  bit           bp_rand;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: pad the whole message as a flat byte list, then cut it into 64-byte blocks.
  function automatic void build_model();
    logic [7:0]  p[$];
    logic [63:0] bl;
    logic [511:0] blk;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg_q.size()) * 64'd8;
    for (int k = LW; k < 64; k++) bl[k] = 1'b0;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      exp_q.push_back(blk);
    end
  endfunction

  task automatic send_msg(input bit with_last);
    int unsigned i = 0;
    int unsigned budget = 0;
    int unsigned n = msg_q.size();
    bit xfer;
    @(posedge CLK); #1;
    while (i < n && budget < 5000) begin
      in_valid = iv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = msg_q[i];
      if (in_valid) in_last = with_last && (i == n - 1);
      else          in_last = iv_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLK);
      xfer = in_valid && in_ready;
      if (xfer && i == n - 1) last_xfer_cyc = cyc;
      @(posedge CLK); #1;
      if (xfer) i++;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic recv_blocks(input int unsigned n);
    for (int b = 0; b < exp_q.size(); b++) begin
      int unsigned  budget = 0;
      int unsigned  rise = 0;
      bit           seen = 0;
      bit           done = 0;
      logic [511:0] hd;
      logic         hf, hl;
      while (!done && budget < 5000) begin
        @(posedge CLK); #1;
        blk_ready = bp_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        @(negedge CLK);
        budget++;
        if (blk_valid) begin
          if (!seen) begin
            seen = 1; rise = cyc; hd = blk_data; hf = blk_first; hl = blk_last;
          end else begin
            chk("hold_data", blk_data, hd);
            chk("hold_first", blk_first, hf);
            chk("hold_last", blk_last, hl);
          end
          chk("in_ready_emit", in_ready, 1'b0);
          if (blk_ready) begin
            chk("data", blk_data, exp_q[b]);
            chk("first", blk_first, b == 0);
            chk("last", blk_last, b == exp_q.size() - 1);
            if (b == (n - 1) / 64) chk("latency", rise - last_xfer_cyc, (n % 64 == 0) ? 1 : 2);
`ifdef SHA256_PAD_OVF_EN
            if (b == exp_q.size() - 1) chk("ovf_final", len_ovf, (64'(n) * 64'd8) >= (64'd1 << LW));
`endif
            last_rx = blk_data;
            done = 1;
          end
        end
      end
      if (!done) chk("recv_timeout", 1'b0, 1'b1);
    end
    @(posedge CLK); #1;
    blk_ready = 1'b0;
  endtask

  task automatic run_msg();
    int unsigned n = msg_q.size();
    build_model();
    fork
      send_msg(1'b1);
      recv_blocks(n);
    join
`ifdef SHA256_PAD_OVF_EN
    @(negedge CLK);
    chk("ovf_cleared", len_ovf, 1'b0);
`endif
  endtask

  task automatic fill(input int unsigned n, input int fixed);
    msg_q.delete();
    for (int unsigned i = 0; i < n; i++)
      msg_q.push_back(fixed < 0 ? 8'($urandom) : 8'(fixed));
  endtask

  task automatic reset_pulse();
    @(posedge CLK); #1;
    nreset = 1'b0;
    #1;
    chk("rst_valid", blk_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_data", blk_data, '0);
    chk("rst_first", blk_first, 1'b0);
    @(posedge CLK); #1;
    nreset = 1'b1;
  endtask

  initial begin
    int unsigned  budget;
    int unsigned  n;
    logic [511:0] hd;
    int unsigned  bnd[11] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};

    nreset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; blk_ready = 1'b0;
    iv_rand = 0; bp_rand = 0;
    #12;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_valid", blk_valid, 1'b0);
    chk("reset_first", blk_first, 1'b0);
    chk("reset_last", blk_last, 1'b0);
    chk("reset_data", blk_data, '0);
    nreset = 1'b1;
    @(posedge CLK); #1;
    chk("post_reset_in_ready", in_ready, 1'b1);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg();
    chk("abc_block", last_rx, {32'h61626380, 472'h0, 8'h18});
    fill(55, 8'h00); run_msg();
    fill(56, 8'hAA); run_msg();
    fill(64, 8'h11); run_msg();
`ifdef SHA256_PAD_OVF_EN
    fill(33, -1); run_msg();
`endif

    iv_rand = 1; bp_rand = 1;
    for (int t = 0; t < 25; t++) begin
      n = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 10)] : $urandom_range(1, 200);
      fill(n, -1);
      run_msg();
    end
    iv_rand = 0; bp_rand = 0;

    // Backpressure on a full data block, then reset while it is presented.
    fill(64, -1);
    build_model();
    blk_ready = 1'b0;
    send_msg(1'b1);
    budget = 0;
    @(negedge CLK);
    while (!blk_valid && budget < 20) begin @(negedge CLK); budget++; end
    chk("bp_valid", blk_valid, 1'b1);
    hd = blk_data;
    chk("bp_data", hd, exp_q[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_hold_data", blk_data, hd);
      chk("bp_hold_first", blk_first, 1'b1);
      chk("bp_hold_last", blk_last, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    reset_pulse();

    fill(10, -1);
    send_msg(1'b0);
    reset_pulse();
    @(negedge CLK);
    chk("after_rst_valid", blk_valid, 1'b0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg();
    chk("abc_after_rst", last_rx, {32'h61626380, 472'h0, 8'h18});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
